// File: rtl/aer_event_fifo_if.sv
// aer_event_fifo_if: conv-layer write port and pooling-layer read-request/valid port of the AER event FIFO.
interface aer_event_fifo_if #(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 6,
    parameter int DROP_W = 16
);
    logic [DATA_W-1:0] Conv_spike_AER_i;
    logic              Conv_spike_emit_flag;
    logic              Read_req;
    logic [DATA_W-1:0] AER_data_o;
    logic              AER_data_valid_o;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W:0]   fifo_level;
    logic [DROP_W-1:0] drop_cnt;

    modport master (
        output Conv_spike_AER_i, Conv_spike_emit_flag, Read_req,
        input  AER_data_o, AER_data_valid_o, fifo_full, fifo_empty, fifo_level, drop_cnt
    );

    modport slave (
        input  Conv_spike_AER_i, Conv_spike_emit_flag, Read_req,
        output AER_data_o, AER_data_valid_o, fifo_full, fifo_empty, fifo_level, drop_cnt
    );
endinterface

// File: rtl/aer_event_fifo.sv
// aer_event_fifo: circular buffer of AER spike events, served one event per request with a one-cycle valid pulse.
module aer_event_fifo #(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 6,
    parameter int DROP_W = 16
) (
    input logic            work_clk,
    input logic            rst_n,
    aer_event_fifo_if.slave bus
);
    localparam logic [0:0]      R_IDLE    = 1'b0;
    localparam logic [0:0]      R_PRESENT = 1'b1;
    localparam logic [ADDR_W:0] DEPTH     = (ADDR_W+1)'(2**ADDR_W);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [0:0]        r_state;
    logic [DROP_W-1:0] r_drop;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_wr;

    assign w_full  = r_count == DEPTH;
    assign w_empty = r_count == '0;
    // R_PRESENT locks out popping so a request still high in the valid cycle cannot take a second event
    assign w_pop   = r_state == R_IDLE && bus.Read_req && !w_empty;
    assign w_wr    = bus.Conv_spike_emit_flag && (!w_full || w_pop);

    always_ff @(posedge work_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= bus.Conv_spike_AER_i;
    end

    always_ff @(posedge work_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_state  <= R_IDLE;
            r_data   <= '0;
            r_drop   <= '0;
        end else begin
            r_state <= w_pop ? R_PRESENT : R_IDLE;
            if (w_wr) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
                r_data   <= r_mem[r_rd_ptr];
            end
            if (w_wr && !w_pop) r_count <= r_count + (ADDR_W+1)'(1);
            else if (!w_wr && w_pop) r_count <= r_count - (ADDR_W+1)'(1);
            if (bus.Conv_spike_emit_flag && !w_wr && r_drop != '1) r_drop <= r_drop + DROP_W'(1);
        end
    end

    assign bus.AER_data_o       = r_data;
    assign bus.AER_data_valid_o = r_state == R_PRESENT;
    assign bus.fifo_full        = w_full;
    assign bus.fifo_empty       = w_empty;
    assign bus.fifo_level       = r_count;
    assign bus.drop_cnt         = r_drop;
endmodule

// File: tb/tb_aer_event_fifo.sv
// tb_aer_event_fifo: randomized and directed stimulus against a queue-based FIFO model with a scoreboard monitor.
module tb_aer_event_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aer_event_fifo_if #(.DATA_W(18), .ADDR_W(6), .DROP_W(16)) bus ();

    aer_event_fifo #(.DATA_W(18), .ADDR_W(6), .DROP_W(16)) dut (
        .work_clk(clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int n_valid = 0;

    logic [17:0] m_q[$];
    logic [17:0] exp_q[$];
    logic [17:0] m_last = '0;
    logic [15:0] m_drop = '0;
    bit          m_pres = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: the FIFO as a queue; a pop is allowed only when the previous cycle did not pop
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            exp_q.delete();
            m_last = '0;
            m_drop = '0;
            m_pres = 1'b0;
        end else begin
            bit pop, acc;
            pop = !m_pres && bus.Read_req && m_q.size() > 0;
            acc = bus.Conv_spike_emit_flag && (m_q.size() < 64 || pop);
            if (pop) begin
                m_last = m_q.pop_front();
                exp_q.push_back(m_last);
            end
            if (acc) m_q.push_back(bus.Conv_spike_AER_i);
            else if (bus.Conv_spike_emit_flag && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            m_pres = pop;
        end
    end

    always @(negedge clk) begin
        chk("valid", 32'(bus.AER_data_valid_o), 32'(m_pres));
        if (bus.AER_data_valid_o) begin
            n_valid++;
            if (exp_q.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
            else chk("data", 32'(bus.AER_data_o), 32'(exp_q.pop_front()));
        end
        chk("data_hold", 32'(bus.AER_data_o), 32'(m_last));
        chk("level", 32'(bus.fifo_level), 32'(m_q.size()));
        chk("full", 32'(bus.fifo_full), 32'(m_q.size() == 64));
        chk("empty", 32'(bus.fifo_empty), 32'(m_q.size() == 0));
        chk("drop", 32'(bus.drop_cnt), 32'(m_drop));
    end

    task automatic step(input logic e, input logic [17:0] d, input logic r);
        bus.Conv_spike_emit_flag = e;
        bus.Conv_spike_AER_i     = d;
        bus.Read_req             = r;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (m_q.size() > 0 || m_pres); i++) step(1'b0, 18'd0, 1'b1);
        step(1'b0, 18'd0, 1'b0);
        chk("drain_level", 32'(bus.fifo_level), 32'd0);
    endtask

    initial begin
        int v0;
        bus.Conv_spike_emit_flag = 1'b0;
        bus.Conv_spike_AER_i     = '0;
        bus.Read_req             = 1'b0;
        #12;
        chk("rst_valid", 32'(bus.AER_data_valid_o), 32'd0);
        chk("rst_data", 32'(bus.AER_data_o), 32'd0);
        chk("rst_level", 32'(bus.fifo_level), 32'd0);
        chk("rst_empty", 32'(bus.fifo_empty), 32'd1);
        chk("rst_full", 32'(bus.fifo_full), 32'd0);
        chk("rst_drop", 32'(bus.drop_cnt), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b0, 18'd0, 1'b0);

        // single event, request held: exactly one pulse
        v0 = n_valid;
        step(1'b1, 18'h20A05, 1'b0);
        repeat (6) step(1'b0, 18'd0, 1'b1);
        chk("single_pulses", 32'(n_valid - v0), 32'd1);
        chk("single_empty", 32'(bus.fifo_empty), 32'd1);
        chk("single_data", 32'(bus.AER_data_o), 32'h20A05);

        // lockout: three events, request held ten cycles
        v0 = n_valid;
        for (int i = 0; i < 3; i++) step(1'b1, 18'(18'h100 + i), 1'b0);
        chk("lock_level3", 32'(bus.fifo_level), 32'd3);
        repeat (10) step(1'b0, 18'd0, 1'b1);
        step(1'b0, 18'd0, 1'b0);
        chk("lock_pulses", 32'(n_valid - v0), 32'd3);
        chk("lock_level0", 32'(bus.fifo_level), 32'd0);

        // overflow: 70 writes into 64 slots
        for (int i = 0; i < 64; i++) step(1'b1, 18'(i * 1021 + 7), 1'b0);
        chk("ovf_full64", 32'(bus.fifo_full), 32'd1);
        chk("ovf_drop0", 32'(bus.drop_cnt), 32'd0);
        for (int i = 64; i < 70; i++) step(1'b1, 18'(i * 1021 + 7), 1'b0);
        chk("ovf_drop6", 32'(bus.drop_cnt), 32'd6);
        chk("ovf_level", 32'(bus.fifo_level), 32'd64);

        // full with simultaneous write and pop
        step(1'b1, 18'h3BEEF, 1'b1);
        step(1'b0, 18'd0, 1'b0);
        chk("fullpop_drop", 32'(bus.drop_cnt), 32'd6);
        chk("fullpop_level", 32'(bus.fifo_level), 32'd64);
        drain();
        chk("fullpop_last", 32'(bus.AER_data_o), 32'h3BEEF);

        // wrap-around: random interleaved traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 18'($urandom), 1'($urandom_range(0, 2) == 0));
        drain();

        // reset while presenting with ten stored events
        for (int i = 0; i < 11; i++) step(1'b1, 18'(18'h2000 + i), 1'b0);
        step(1'b0, 18'd0, 1'b1);
        bus.Read_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.AER_data_valid_o), 32'd0);
        chk("mid_rst_level", 32'(bus.fifo_level), 32'd0);
        chk("mid_rst_drop", 32'(bus.drop_cnt), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        v0 = n_valid;
        step(1'b1, 18'h15555, 1'b0);
        repeat (5) step(1'b0, 18'd0, 1'b1);
        chk("post_rst_pulses", 32'(n_valid - v0), 32'd1);
        chk("post_rst_data", 32'(bus.AER_data_o), 32'h15555);
        chk("post_rst_empty", 32'(bus.fifo_empty), 32'd1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/aer_event_fifo.md
# aer_event_fifo

Buffers convolution-layer AER spike events and serves them to the pooling layer through its read-request / one-cycle-valid handshake. It is the responder end of that interface: the conv layer pushes 18-bit events on a write strobe, and the pooling layer pulls one event per request. It sits between the conv spike encoder and the pooling layer, absorbing bursts and counting events dropped on overflow.

## Interface
- DATA_W, 18, event width: [17:16] spike channel, [15:8] M (row), [7:0] N (column)
- ADDR_W, 6, log2 of depth; depth = 2^ADDR_W = 64
- DROP_W, 16, width of the saturating drop counter

- work_clk  in  1  single clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- Conv_spike_AER_i  in  DATA_W  event to store
- Conv_spike_emit_flag  in  1  write strobe, one event per high cycle
- Read_req  in  1  pooling layer requests one event (registered by the requester)
- AER_data_o  out  DATA_W  event presented to the reader
- AER_data_valid_o  out  1  one-cycle pulse, AER_data_o valid; drives the pooling layer's FIFO-valid input
- fifo_full  out  1  count == 2^ADDR_W
- fifo_empty  out  1  count == 0
- fifo_level  out  ADDR_W+1  stored event count
- drop_cnt  out  DROP_W  events rejected while full, saturating at all-ones

## Operation
- Storage: 2^ADDR_W x DATA_W circular buffer, wr_ptr/rd_ptr ADDR_W bits wrapping modulo depth, count ADDR_W+1 bits.
- Write: when Conv_spike_emit_flag=1, accept if !fifo_full or a pop occurs in the same cycle. Store at wr_ptr, wr_ptr+1. Otherwise drop, drop_cnt+1 (saturate).
- Read FSM, 2 states:
  - R_IDLE: pop when Read_req=1 and !fifo_empty. Register AER_data_o <= mem[rd_ptr], rd_ptr+1, go to R_PRESENT. Otherwise stay; AER_data_valid_o=0.
  - R_PRESENT: AER_data_valid_o=1 for exactly this cycle; no pop regardless of Read_req; always return to R_IDLE.
- The R_PRESENT lockout is mandatory. The requester's Read_req is still high in the valid cycle, and the lockout keeps a single request from popping two events.
- count: +1 on accepted write only, -1 on pop only, unchanged on both or neither.
- AER_data_o holds its last value between pops and is not cleared on pop.
- fifo_full, fifo_empty, and fifo_level are derived from the registered count. They reflect the state after the previous edge.

## Timing
- Reset, asynchronous, any state: wr_ptr=rd_ptr=count=0, FSM=R_IDLE, AER_data_o=0, AER_data_valid_o=0, drop_cnt=0, fifo_empty=1, fifo_full=0, fifo_level=0. Memory contents are not cleared. An event in flight (R_PRESENT) is lost.
- Write-to-readable latency: an event written at edge k raises count at edge k. A pop can occur at edge k+1 at the earliest. There is no same-cycle bypass when empty.
- Request-to-valid latency: Read_req sampled high at edge t (R_IDLE, non-empty) gives AER_data_valid_o=1 and data during cycle t..t+1. The next pop is at edge t+2 at the earliest.
- Maximum drain rate: 1 event per 2 cycles.
- Full + write + pop in same cycle: write accepted, count stays at depth, no drop.
- Empty + write + Read_req in same cycle: write accepted, no pop; the pop occurs the next cycle if Read_req is still high.
- Pointer wrap from 2^ADDR_W-1 to 0 must be transparent to ordering (strict FIFO order).
- drop_cnt at all-ones stays at all-ones on further drops.

## Test plan
- Reset/single event: after reset, check all outputs at reset values. Write 0x2_0A_05 (ch=2, M=0x0A, N=0x05). Hold Read_req=1 from the next cycle. Require exactly one valid pulse with AER_data_o=0x20A05 one cycle after Read_req is sampled, then fifo_empty=1 and no second pulse.
- Lockout: 3 events stored, Read_req held high for 10 cycles. Require valid pulses every other cycle (3 pulses, in order), then none; fifo_level goes 3→0.
- Overflow: with Read_req=0, write 70 distinct events. Require fifo_full=1 after 64, drop_cnt=6, and a later drain returning events 0..63 in order.
- Full with simultaneous pop: fill to 64, then issue a write and a pop on the same edge. Require drop_cnt unchanged, fifo_level=64, and the new event read out 64th from now.
- Wrap-around: 200 events with interleaved writes and requests. Require output order identical to input order and fifo_level never exceeding 64.
- Reset mid-operation: assert rst_n=0 during R_PRESENT with 10 events stored. Require immediate AER_data_valid_o=0, fifo_level=0, drop_cnt=0. After release, a new write/read returns only the new event.
